// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg -- shared types for the load/store unit.
//   lsu_state_t : access sequencer states (REQ1/WAIT1 exist only when the
//                 two-beat misaligned split is built in via LSU_MISALIGN_EN)
//   mem_size_t  : access size encoding carried on req_size
//   size_bytes  : number of bytes touched by an access of a given size
// Config macro: LSU_MISALIGN_EN
// ---------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        WAIT0,
`ifdef LSU_MISALIGN_EN
        REQ1,
        WAIT1,
`endif
        RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } mem_size_t;

    function automatic logic [3:0] size_bytes(mem_size_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align -- combinational byte-lane steering for the LSU.
//   offset/size/is_unsigned : byte offset inside an XLEN/8 word, access size,
//                             zero-extend select
//   wdata                   : LSB-aligned store data
//   rdata_lo/rdata_hi       : load data of beat 0 / beat 1
//   ben0/ben1               : active-low byte enables for beat 0 / beat 1
//   wdata0/wdata1           : store data steered onto the lanes of each beat
//   misaligned              : access reaches into the following word
//   load_data               : merged, right-justified, extended load result
// ---------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int NB = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [OFF_W-1:0] offset,
    input  logic [1:0]       size,
    input  logic             is_unsigned,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata_lo,
    input  logic [XLEN-1:0]  rdata_hi,
    output logic [NB-1:0]    ben0,
    output logic [NB-1:0]    ben1,
    output logic [XLEN-1:0]  wdata0,
    output logic [XLEN-1:0]  wdata1,
    output logic             misaligned,
    output logic [XLEN-1:0]  load_data
);

    logic [3:0]        nbytes;
    logic [2*NB-1:0]   acc_mask;   // bytes touched, across both beats
    logic [2*XLEN-1:0] wide_w;
    logic [2*XLEN-1:0] wide_r;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   keep;       // bits belonging to the access itself
    logic              sign;

    assign nbytes   = size_bytes(mem_size_t'(size));
    assign acc_mask = ~({(2*NB){1'b1}} << nbytes) << offset;

    assign ben0       = ~acc_mask[NB-1:0];
    assign ben1       = ~acc_mask[2*NB-1:NB];
    assign misaligned = |acc_mask[2*NB-1:NB];

    // Store bytes pushed past the top lane overflow into the second beat.
    assign wide_w = {{XLEN{1'b0}}, wdata} << {offset, 3'b000};
    assign wdata0 = wide_w[XLEN-1:0];
    assign wdata1 = wide_w[2*XLEN-1:XLEN];

    assign wide_r  = {rdata_hi, rdata_lo} >> {offset, 3'b000};
    assign shifted = wide_r[XLEN-1:0];

    // A shift of 8*nbytes >= XLEN empties the vector, so full-width accesses
    // keep every bit and are never extended.
    assign keep = ~({XLEN{1'b1}} << {nbytes, 3'b000});
    // keep is contiguous from bit 0, so keep ^ (keep >> 1) isolates its MSB.
    assign sign = ~is_unsigned & |(shifted & (keep ^ (keep >> 1)));

    assign load_data = (shifted & keep) | (~keep & {XLEN{sign}});

endmodule

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between the core and a req/gnt/rvalid memory port.
//   req_*  : core request (valid/ready handshake), captured on accept
//   rsp_*  : one-cycle completion pulse with extended load data, tag, fault
//   mem_*  : memory port; mem_addr is XLEN/8 aligned, mem_ben active-low
// Accesses that cross an XLEN/8 word boundary are split into two beats when
// LSU_MISALIGN_EN is defined; otherwise they fault without memory traffic.
// dword accesses fault when XLEN=32.
// Config macro: LSU_MISALIGN_EN
// ---------------------------------------------------------------------------
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic              mem_we,
    output logic [XLEN/8-1:0] mem_ben,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t        state, state_d, after_beat0;
    logic              accept, fault_in, beat1, in_wait;
    logic              cap_write, cap_unsigned, cap_fault;
    logic [1:0]        cap_size;
    logic [ADDR_W-1:0] cap_addr, word_addr;
    logic [XLEN-1:0]   cap_wdata, rbuf_lo, rbuf_hi;
    logic [4:0]        cap_rd;

    logic [OFF_W-1:0]  al_offset;
    logic [1:0]        al_size;
    logic [NB-1:0]     ben0, ben1;
    logic [XLEN-1:0]   wdata0, wdata1, load_data;
    logic              misaligned;

    assign accept = req_valid && (state == IDLE);

    // In IDLE the aligner looks at the incoming request so the fault decision
    // is available at the accept edge; afterwards it works on captured fields.
    assign al_offset = (state == IDLE) ? req_addr[OFF_W-1:0] : cap_addr[OFF_W-1:0];
    assign al_size   = (state == IDLE) ? req_size : cap_size;

    lsu_align #(.XLEN(XLEN)) u_align (
        .offset      (al_offset),
        .size        (al_size),
        .is_unsigned (cap_unsigned),
        .wdata       (cap_wdata),
        .rdata_lo    (rbuf_lo),
        .rdata_hi    (rbuf_hi),
        .ben0        (ben0),
        .ben1        (ben1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .misaligned  (misaligned),
        .load_data   (load_data)
    );

`ifdef LSU_MISALIGN_EN
    assign fault_in    = (mem_size_t'(req_size) == DWORD) && (XLEN == 32);
    assign beat1       = (state == REQ1) || (state == WAIT1);
    assign after_beat0 = misaligned ? REQ1 : RESP;
`else
    assign fault_in    = ((mem_size_t'(req_size) == DWORD) && (XLEN == 32)) || misaligned;
    assign beat1       = 1'b0;
    assign after_beat0 = RESP;
`endif

    // NOTE: every output of this block is given a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        mem_req = 1'b0;
        in_wait = 1'b0;
        case (state)
            IDLE:  if (req_valid) state_d = fault_in ? RESP : REQ0;
            REQ0: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = cap_write ? after_beat0 : WAIT0;
            end
            WAIT0: begin
                in_wait = 1'b1;
                if (mem_rvalid) state_d = after_beat0;
            end
`ifdef LSU_MISALIGN_EN
            REQ1: begin
                mem_req = 1'b1;
                if (mem_gnt) state_d = cap_write ? RESP : WAIT1;
            end
            WAIT1: begin
                in_wait = 1'b1;
                if (mem_rvalid) state_d = RESP;
            end
`endif
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cap_write    <= 1'b0;
            cap_size     <= 2'd0;
            cap_unsigned <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_rd       <= 5'd0;
            cap_fault    <= 1'b0;
            rbuf_lo      <= '0;
            rbuf_hi      <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                cap_write    <= req_write;
                cap_size     <= req_size;
                cap_unsigned <= req_unsigned;
                cap_addr     <= req_addr;
                cap_wdata    <= req_wdata;
                cap_rd       <= req_rd;
                cap_fault    <= fault_in;
            end
            if (in_wait && mem_rvalid) begin
                if (beat1) rbuf_hi <= mem_rdata;
                else       rbuf_lo <= mem_rdata;
            end
        end
    end

    assign word_addr = {cap_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    assign req_ready = (state == IDLE);
    assign mem_we    = mem_req && cap_write;
    assign mem_ben   = mem_req ? (beat1 ? ben1 : ben0) : '1;
    // Beat 1 address wraps naturally modulo 2^ADDR_W.
    assign mem_addr  = beat1 ? word_addr + ADDR_W'(NB) : word_addr;
    assign mem_wdata = beat1 ? wdata1 : wdata0;

    assign rsp_valid = (state == RESP);
    assign rsp_fault = rsp_valid && cap_fault;
    assign rsp_rd    = rsp_valid ? cap_rd : 5'd0;
    assign rsp_rdata = (rsp_valid && !cap_fault && !cap_write) ? load_data : '0;

endmodule
